// File: rtl/pc_redirect_pkg.sv
// Shared types and constants for the PC redirect unit.
package pc_redirect_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } redirect_state_e;

    localparam logic [1:0]  BRANCH_TAKEN     = 2'b11;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC00000;

endpackage

// File: rtl/pc_redirect_unit.sv
// Fetch-address generator with a fixed number of delay slots.
// Transfers are latched and applied after SLOTS further retired instructions.
module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      SLOTS    = 1,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       Branch,
    input  logic             Jump,
    input  logic             JR,
    input  logic [WIDTH-1:0] branch_address,
    input  logic [WIDTH-1:0] jump_address,
    input  logic [WIDTH-1:0] rs_content,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_pc,
    output logic [WIDTH-1:0] next_pc,
    output logic             in_delay_slot,
    output logic             redirect,
    output logic             slot_violation,
    output logic             target_misaligned
);

    localparam int unsigned CW = $clog2(SLOTS + 1);

    generate
        if (SLOTS < 1 || SLOTS > 4) begin : g_bad_slots
            $error("pc_redirect_unit: SLOTS must be in 1..4");
        end
    endgenerate

    redirect_state_e  state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] next_pc_q;
    logic             in_delay_slot_q;
    logic             redirect_q;
    logic             slot_violation_q;
    logic             target_misaligned_q;

    logic             advance_d;
    logic             transfer_d;
    logic [WIDTH-1:0] target_d;
    logic [WIDTH-1:0] pc_plus4_d;

    always_comb begin
        advance_d  = instr_valid && !stall;
        transfer_d = (Branch == BRANCH_TAKEN) || Jump || JR;
        pc_plus4_d = pc + WIDTH'(4);
        if (Branch == BRANCH_TAKEN) begin
            target_d = branch_address;
        end else if (Jump) begin
            target_d = jump_address;
        end else begin
            target_d = rs_content;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            cnt_q               <= '0;
            target_q            <= '0;
            next_pc_q           <= RESET_PC;
            in_delay_slot_q     <= 1'b0;
            redirect_q          <= 1'b0;
            slot_violation_q    <= 1'b0;
            target_misaligned_q <= 1'b0;
        end else begin
            redirect_q          <= 1'b0;
            slot_violation_q    <= 1'b0;
            target_misaligned_q <= 1'b0;
            if (flush) begin
                // Exception redirect wins even while stalled and drops any pending target.
                next_pc_q       <= flush_pc;
                state_q         <= ST_IDLE;
                cnt_q           <= '0;
                in_delay_slot_q <= 1'b0;
                redirect_q      <= 1'b1;
            end else if (advance_d) begin
                case (state_q)
                    ST_IDLE: begin
                        next_pc_q <= pc_plus4_d;
                        if (transfer_d) begin
                            target_q            <= target_d;
                            cnt_q               <= CW'(SLOTS);
                            state_q             <= ST_PENDING;
                            in_delay_slot_q     <= 1'b1;
                            target_misaligned_q <= |target_d[1:0];
                        end
                    end
                    ST_PENDING: begin
                        // A transfer in a delay slot is flagged but still consumes the slot.
                        slot_violation_q <= transfer_d;
                        if (cnt_q > CW'(1)) begin
                            cnt_q     <= cnt_q - CW'(1);
                            next_pc_q <= pc_plus4_d;
                        end else begin
                            cnt_q           <= '0;
                            next_pc_q       <= target_q;
                            redirect_q      <= 1'b1;
                            state_q         <= ST_IDLE;
                            in_delay_slot_q <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign next_pc           = next_pc_q;
    assign in_delay_slot     = in_delay_slot_q;
    assign redirect          = redirect_q;
    assign slot_violation    = slot_violation_q;
    assign target_misaligned = target_misaligned_q;

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter SLOTS, default 1, delay-slot count before a redirect takes effect (legal 1..4).
REQ-003 SHALL have parameter RESET_PC, default 32'hBFC00000, fetch address after reset.
REQ-004 SHALL have clk  input  1  sole clock, all state updates on posedge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have stall  input  1  holds all state when high.
REQ-007 SHALL have instr_valid  input  1  instruction at pc retires from decode this cycle.
REQ-008 SHALL have pc  input  WIDTH  address of the instruction being decoded.
REQ-009 SHALL have Branch  input  2  value 2'b11 = conditional branch taken.
REQ-010 SHALL have Jump  input  1  J/JAL; JR  input  1  JR/JALR.
REQ-011 SHALL have branch_address, jump_address, rs_content  input  WIDTH  candidate targets.
REQ-012 SHALL have flush  input  1  and flush_pc  input  WIDTH  exception redirect.
REQ-013 SHALL have next_pc  output  WIDTH  registered fetch address.
REQ-014 SHALL have in_delay_slot  output  1  high while a redirect is pending.
REQ-015 SHALL have redirect  output  1  one-cycle pulse when next_pc loads a target.
REQ-016 SHALL have slot_violation, target_misaligned  output  1  one-cycle error pulses.

Function
REQ-017 "Advance" SHALL mean instr_valid=1 and stall=0 in a cycle; "transfer" SHALL mean Branch==2'b11 or Jump or JR.
REQ-018 Target selection priority SHALL be Branch==2'b11 > Jump > JR (branch_address, jump_address, rs_content).
REQ-019 States SHALL be IDLE and PENDING; PENDING holds target register and slot counter cnt (width clog2(SLOTS+1)).
REQ-020 IDLE, advance, no transfer: next_pc <= pc + 4, stay IDLE.
REQ-021 IDLE, advance, transfer: latch target, cnt <= SLOTS, next_pc <= pc + 4, go PENDING, in_delay_slot <= 1.
REQ-022 PENDING, advance, cnt>1: cnt <= cnt-1, next_pc <= pc + 4.
REQ-023 PENDING, advance, cnt==1: next_pc <= target, redirect pulse, go IDLE, in_delay_slot <= 0.
REQ-024 Transfer during PENDING SHALL be ignored for targeting, SHALL pulse slot_violation, SHALL still count as a slot.
REQ-025 No advance (stall=1 or instr_valid=0): all registers hold; pulses deassert.
REQ-026 flush=1 (stall irrelevant): next_pc <= flush_pc, state IDLE, cnt <= 0, redirect pulse; overrides REQ-020..025.
REQ-027 target_misaligned SHALL pulse in the latch cycle when the selected target bits [1:0] != 0; target still used unmodified.
REQ-028 pc + 4 SHALL wrap modulo 2^WIDTH.
REQ-029 Latency: target visible on next_pc the cycle after the SLOTS-th advance following the transfer.

Reset
REQ-030 reset SHALL take priority over flush and all other inputs.
REQ-031 On reset: next_pc=RESET_PC, state IDLE, cnt=0, target=0, in_delay_slot=0, redirect=0, slot_violation=0, target_misaligned=0.
REQ-032 Reset mid-PENDING SHALL discard the pending target with no redirect pulse.

Structure
REQ-033 pc_redirect_pkg SHALL hold the state enum, BRANCH_TAKEN=2'b11 constant and default RESET_PC.
REQ-034 Single module, no sub-module; one sequential block plus combinational target select.
REQ-035 Elaboration SHALL fail for SLOTS outside 1..4.

Verification
REQ-036 Reset then idle: next_pc=32'hBFC00000, all pulses 0.
REQ-037 SLOTS=1, pc=0x100 Branch=2'b11 branch_address=0x200, then advance pc=0x104 -> next_pc 0x104, then 0x200 with redirect=1.
REQ-038 SLOTS=2, JR rs_content=0x400 at pc=0x10, stall 3 cycles in slot 1 -> next_pc holds 0x14, lands 0x400 only after two advances.
REQ-039 SLOTS=1, Jump at 0x20 (target 0x80) then Branch=2'b11 in delay slot -> slot_violation=1, next_pc=0x80.
REQ-040 Pending branch, flush=1 flush_pc=0x80000180 -> next_pc=0x80000180, in_delay_slot=0, no later redirect to branch target.
REQ-041 pc=0xFFFFFFFC no transfer -> next_pc=0x00000000; JR rs_content=0x102 -> target_misaligned=1.
